// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_arbiter_if
//  Brief    : Cache-side request/response and RAM-side bus of the memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface cache_mem_arbiter_if;
    // icache side
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    // dcache side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    // RAM side
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    // Arbiter view
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Caches + RAM view
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_arbiter
//  Brief    : Serializes icache/dcache accesses onto one word-wide RAM port.
//             Optional macro ARB_ROUND_ROBIN_EN: alternate winner on contention.
//  Revision : 1.0  initial release
// ============================================================================
module cache_mem_arbiter (
    input  wire logic          CLK,
    input  wire logic          nRST,
    cache_mem_arbiter_if.slave bus
);
    localparam logic [1:0] c_RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        DCACHE = 2'd1,
        ICACHE = 2'd2
    } owner_t;

    owner_t r_owner;
    owner_t w_owner_next;
    owner_t w_arb;
    owner_t w_owner;
    logic   w_dreq;
    logic   w_ireq;
    logic   w_owner_req;
    logic   w_done;

    assign w_dreq = bus.dREN | bus.dWEN;
    assign w_ireq = bus.iREN;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = icache won the last completed grant, so dcache wins the next tie
    logic r_last_icache;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST)
            r_last_icache <= 1'b1;
        else if (w_done)
            r_last_icache <= (w_owner == ICACHE);
    end

    always_comb begin
        w_arb = NONE;
        if (w_dreq && w_ireq)
            w_arb = r_last_icache ? DCACHE : ICACHE;
        else if (w_dreq)
            w_arb = DCACHE;
        else if (w_ireq)
            w_arb = ICACHE;
    end
`else
    always_comb begin
        w_arb = NONE;
        if (w_dreq)
            w_arb = DCACHE;
        else if (w_ireq)
            w_arb = ICACHE;
    end
`endif

    // Reset gates the combinational grant so no strobe escapes while nRST is high
    always_comb begin
        w_owner = NONE;
        if (!nRST)
            w_owner = (r_owner != NONE) ? r_owner : w_arb;
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST)
            r_owner <= NONE;
        else
            r_owner <= w_owner_next;
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'd0;
        bus.ramstore = 32'd0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = 32'd0;
        bus.dload    = 32'd0;
        w_owner_req  = 1'b0;

        case (w_owner)
            DCACHE: begin
                w_owner_req  = w_dreq;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
            end
            ICACHE: begin
                w_owner_req  = w_ireq;
                bus.ramREN   = bus.iREN;
                bus.ramaddr  = bus.iaddr;
            end
            default: ;
        endcase

        w_done = w_owner_req && (bus.ramstate == c_RAM_ACCESS);

        if (w_done && (w_owner == DCACHE)) begin
            bus.dwait = 1'b0;
            bus.dload = bus.ramload;
        end
        if (w_done && (w_owner == ICACHE)) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
        end

        // Ownership is kept only while the owner still requests and has not finished
        w_owner_next = (w_owner_req && !w_done) ? w_owner : NONE;
    end
endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_mem_arbiter
//  Brief    : Scoreboard bench for cache_mem_arbiter with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_mem_arbiter;
    localparam logic [1:0] c_FREE   = 2'd0;
    localparam logic [1:0] c_BUSY   = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_ERROR  = 2'd3;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic        iw;
        logic        dw;
        logic [31:0] il;
        logic [31:0] dl;
    } exp_t;

    logic CLK;
    logic nRST;
    int   n_checks;
    int   n_errors;
    exp_t q_exp[$];
    string q_tag[$];

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter u_dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: compares the DUT outputs against the oldest expectation each cycle
    initial begin
        exp_t e;
        exp_t g;
        string t;
        n_checks = 0;
        n_errors = 0;
        forever begin
            @(negedge CLK);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                t = q_tag.pop_front();
                g.ren   = bus.ramREN;
                g.wen   = bus.ramWEN;
                g.addr  = bus.ramaddr;
                g.store = bus.ramstore;
                g.iw    = bus.iwait;
                g.dw    = bus.dwait;
                g.il    = bus.iload;
                g.dl    = bus.dload;
                n_checks++;
                if (g !== e) begin
                    n_errors++;
                    $display("FAIL %s: got ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b iload=%h dload=%h | want ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b iload=%h dload=%h",
                             t, g.ren, g.wen, g.addr, g.store, g.iw, g.dw, g.il, g.dl,
                             e.ren, e.wen, e.addr, e.store, e.iw, e.dw, e.il, e.dl);
                end
            end
        end
    end

    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] ds, input logic [1:0] rs, input logic [31:0] rl);
        bus.iREN     = ir;
        bus.iaddr    = ia;
        bus.dREN     = dr;
        bus.dWEN     = dw;
        bus.daddr    = da;
        bus.dstore   = ds;
        bus.ramstate = rs;
        bus.ramload  = rl;
    endtask

    task automatic step(input string tag, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] store,
                        input logic iw, input logic dw,
                        input logic [31:0] il, input logic [31:0] dl);
        exp_t e;
        e = '{ren: ren, wen: wen, addr: addr, store: store, iw: iw, dw: dw, il: il, dl: dl};
        q_exp.push_back(e);
        q_tag.push_back(tag);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b1;
        drive(1, 32'h4, 0, 1, 32'h100, 32'hFEEDCAFE, c_ACCESS, 32'hDEAD);
        @(posedge CLK);
        #1;
        // Reset with live requests: no strobes, both caches wait
        step("reset0", 0, 0, 0, 0, 1, 1, 0, 0);
        step("reset1", 0, 0, 0, 0, 1, 1, 0, 0);
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, c_FREE, 0);
        step("idle", 0, 0, 0, 0, 1, 1, 0, 0);

        // Dcache writes: one BUSY then ACCESS
        drive(0, 0, 0, 1, 32'h100, 32'hFEEDCAFE, c_BUSY, 32'hA5A5A5A5);
        step("wr1_busy", 0, 1, 32'h100, 32'hFEEDCAFE, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 32'h100, 32'hFEEDCAFE, c_ACCESS, 32'hA5A5A5A5);
        step("wr1_acc", 0, 1, 32'h100, 32'hFEEDCAFE, 1, 0, 0, 32'hA5A5A5A5);
        drive(0, 0, 0, 1, 32'h100, 32'hFEEDCAFF, c_BUSY, 32'h0);
        step("wr2_busy", 0, 1, 32'h100, 32'hFEEDCAFF, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 32'h100, 32'hFEEDCAFF, c_ACCESS, 32'h0);
        step("wr2_acc", 0, 1, 32'h100, 32'hFEEDCAFF, 1, 0, 0, 0);

        // dREN and dWEN together: write wins
        drive(0, 0, 1, 1, 32'h200, 32'h11, c_ACCESS, 32'h22);
        step("rdwr", 0, 1, 32'h200, 32'h11, 1, 0, 0, 32'h22);

        // Icache single-cycle read
        drive(1, 32'h4, 0, 0, 0, 0, c_ACCESS, 32'h12345678);
        step("iread", 1, 0, 32'h4, 0, 0, 1, 32'h12345678, 0);

        // Contention: dcache first (last winner is icache under either policy)
        drive(1, 32'h8, 1, 0, 32'h300, 0, c_BUSY, 32'h99);
        step("cont_busy", 1, 0, 32'h300, 0, 1, 1, 0, 0);
        drive(1, 32'h8, 1, 0, 32'h300, 0, c_ACCESS, 32'hCAFEF00D);
        step("cont_dacc", 1, 0, 32'h300, 0, 1, 0, 0, 32'hCAFEF00D);
        drive(1, 32'h8, 1, 0, 32'h300, 0, c_ACCESS, 32'h31313131);
`ifdef ARB_ROUND_ROBIN_EN
        step("cont2_rr", 1, 0, 32'h8, 0, 0, 1, 32'h31313131, 0);
`else
        step("cont2_fix", 1, 0, 32'h300, 0, 1, 0, 0, 32'h31313131);
`endif
        drive(1, 32'h8, 0, 0, 0, 0, c_ACCESS, 32'h0BADBEEF);
        step("cont_iacc", 1, 0, 32'h8, 0, 0, 1, 32'h0BADBEEF, 0);

        // Ownership hold across BUSY/ERROR/FREE while dcache starts requesting
        drive(1, 32'hC, 0, 0, 0, 0, c_BUSY, 32'h0);
        step("hold_busy", 1, 0, 32'hC, 0, 1, 1, 0, 0);
        drive(1, 32'hC, 1, 0, 32'h400, 0, c_ERROR, 32'h0);
        step("hold_err", 1, 0, 32'hC, 0, 1, 1, 0, 0);
        drive(1, 32'hC, 1, 0, 32'h400, 0, c_FREE, 32'h0);
        step("hold_free", 1, 0, 32'hC, 0, 1, 1, 0, 0);
        drive(1, 32'hC, 1, 0, 32'h400, 0, c_ACCESS, 32'h77);
        step("hold_iacc", 1, 0, 32'hC, 0, 0, 1, 32'h77, 0);
        drive(0, 0, 1, 0, 32'h400, 0, c_ACCESS, 32'h88);
        step("hold_dacc", 1, 0, 32'h400, 0, 1, 0, 0, 32'h88);

        // Abort: dcache drops during BUSY, owner still dcache that cycle
        drive(0, 0, 1, 0, 32'h500, 0, c_BUSY, 32'h0);
        step("abort_busy", 1, 0, 32'h500, 0, 1, 1, 0, 0);
        drive(1, 32'h10, 0, 0, 32'h500, 0, c_ACCESS, 32'h66);
        step("abort_drop", 0, 0, 32'h500, 0, 1, 1, 0, 0);
        step("abort_next", 1, 0, 32'h10, 0, 0, 1, 32'h66, 0);

        // Reset mid-transaction
        drive(0, 0, 0, 1, 32'h600, 32'h1234, c_BUSY, 32'h5);
        step("rst_busy", 0, 1, 32'h600, 32'h1234, 1, 1, 0, 0);
        nRST = 1'b1;
        drive(0, 0, 0, 1, 32'h600, 32'h1234, c_ACCESS, 32'h5);
        step("rst_mid", 0, 0, 0, 0, 1, 1, 0, 0);
        nRST = 1'b0;
        step("rst_after", 0, 1, 32'h600, 32'h1234, 1, 0, 0, 32'h5);
        drive(0, 0, 0, 0, 0, 0, c_FREE, 0);
        step("final_idle", 0, 0, 0, 0, 1, 1, 0, 0);

        for (int i = 0; i < 5 && q_exp.size() > 0; i++)
            @(posedge CLK);
        if (q_exp.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
